// File: rtl/decode38_seq_if.sv
// decode38_seq_if
//   Bundles the encoder-side word handshake and the decoded LED outputs of
//   decode38_seq so the decoder and its source/sink share one connection.
//   master : the encoder/switch side (drives en and the input word, watches outputs)
//   slave  : the decoder itself
//   Signals:
//     en        decode enable (mirrors the encoder enable)
//     in_valid  input word present
//     in_ready  decoder FIFO can accept a word (= !full)
//     in_code   encoded index from the encoder
//     in_any    encoder "some input active" flag
//     out       decoded one-hot byte
//     out_valid high while a byte is being held
//     busy      decoder FSM is not idle
//     level     FIFO occupancy
interface decode38_seq_if #(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_code;
    logic             in_any;
    logic [7:0]       out;
    logic             out_valid;
    logic             busy;
    logic [LVL_W-1:0] level;

    modport master (
        output en, in_valid, in_code, in_any,
        input  in_ready, out, out_valid, busy, level
    );

    modport slave (
        input  en, in_valid, in_code, in_any,
        output in_ready, out, out_valid, busy, level
    );
endinterface

// File: rtl/decode38_seq.sv
// decode38_seq
//   Receive side of the 8-3 priority encoder path. Encoded {any, code} words
//   are queued in a small FIFO, then each is expanded into a one-hot byte that
//   is held on the LEDs for HOLD_CYCLES cycles, followed by GAP_CYCLES blank
//   cycles before the next word is taken.
//   Ports:
//     clk  rising-edge system clock
//     rst  synchronous active-high reset (clears FSM, outputs and FIFO)
//     bus  decode38_seq_if.slave: en, in_valid/in_ready/in_code/in_any word
//          handshake, out/out_valid decoded byte, busy, level
module decode38_seq #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic         clk,
    input  logic         rst,
    decode38_seq_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_INIT  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [7:0]       out_q, out_nxt;
    logic             vld_q, vld_nxt;

    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             empty, full, push, pop, load_chk;
    logic [3:0]       head;

    function automatic logic [7:0] decode(input logic [3:0] word);
        return word[3] ? (8'h01 << word[2:0]) : 8'h00;
    endfunction

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);
    // Ready depends on full alone, so a full FIFO refuses a word even on a pop cycle.
    assign push  = bus.in_valid && !full;
    assign head  = mem[rd_ptr_q];

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        out_nxt   = out_q;
        vld_nxt   = vld_q;
        pop       = 1'b0;
        load_chk  = 1'b0;
        case (state_q)
            ST_IDLE: load_chk = 1'b1;
            ST_HOLD: begin
                if (!bus.en) begin
                    // Abort: the current word is dropped, the queue is untouched.
                    out_nxt   = 8'h00;
                    vld_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else begin
                    out_nxt = 8'h00;
                    vld_nxt = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        cnt_nxt   = GAP_INIT;
                        state_nxt = ST_GAP;
                    end else begin
                        load_chk = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                // The last gap cycle doubles as the idle check so the word
                // period is exactly HOLD_CYCLES + GAP_CYCLES.
                if (cnt_q != '0) cnt_nxt = cnt_q - CNT_W'(1);
                else             load_chk = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (load_chk) begin
            if (bus.en && !empty) begin
                pop       = 1'b1;
                out_nxt   = decode(head);
                vld_nxt   = 1'b1;
                cnt_nxt   = HOLD_INIT;
                state_nxt = ST_HOLD;
            end else begin
                out_nxt   = 8'h00;
                vld_nxt   = 1'b0;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            out_q    <= 8'h00;
            vld_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            out_q   <= out_nxt;
            vld_q   <= vld_nxt;
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {bus.in_any, bus.in_code};
    end

    assign bus.in_ready  = !full;
    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.level     = level_q;
endmodule
